// File: rtl/int_ic_pkg.sv
// Shared definitions for the interconnect pulse line: receiver FSM states and
// constants that must agree between transmitter and receiver.
package int_ic_pkg;

  localparam int unsigned INT_PULSE_LEN_DEFAULT = 2;
  localparam int unsigned INT_RUN_W             = 4;

  typedef enum logic [1:0] {
    StIdle  = 2'b00,
    StHigh  = 2'b01,
    StStuck = 2'b10
  } int_rx_state_e;

endpackage

// File: rtl/int_sync_ff.sv
// N-stage flop chain used to bring an asynchronous line into the local clock domain.
module int_sync_ff #(
  parameter int unsigned Stages = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic [Stages-1:0] chain_q, chain_d;

  always_comb begin
    chain_d    = chain_q;
    chain_d[0] = d_i;
    for (int i = 1; i < int'(Stages); i++) begin
      chain_d[i] = chain_q[i-1];
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      chain_q <= '0;
    end else begin
      chain_q <= chain_d;
    end
  end

  assign q_o = chain_q[Stages-1];

endmodule

// File: rtl/int_pulse_receiver.sv
// Recovers fixed-width pulses on the interconnect line as single-cycle strobes,
// counts them, and raises sticky flags for short or stuck-high pulses.
module int_pulse_receiver
  import int_ic_pkg::*;
#(
  parameter int unsigned PULSE_LEN   = INT_PULSE_LEN_DEFAULT,
  parameter int unsigned SYNC_STAGES = 0,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in0,
  input  logic             clr,
  output logic             out0,
  output logic             err_short,
  output logic             err_long,
  output logic [CNT_W-1:0] evt_count
);

  localparam logic [INT_RUN_W-1:0] PulseLenRun = INT_RUN_W'(PULSE_LEN);

  logic line_s;

  if (SYNC_STAGES == 0) begin : g_bypass
    assign line_s = in0;
  end else begin : g_sync
    int_sync_ff #(
      .Stages(SYNC_STAGES)
    ) u_sync (
      .clk_i (clk),
      .rst_ni(rst_n),
      .d_i   (in0),
      .q_o   (line_s)
    );
  end

  int_rx_state_e        state_q, state_d;
  logic [INT_RUN_W-1:0] run_q, run_d;
  logic                 out0_q, out0_d;
  logic                 err_short_q, err_short_d;
  logic                 err_long_q, err_long_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic                 evt, set_short, set_long;

  always_comb begin
    state_d   = state_q;
    run_d     = run_q;
    evt       = 1'b0;
    set_short = 1'b0;
    set_long  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (line_s) begin
          run_d   = INT_RUN_W'(1);
          state_d = StHigh;
        end
      end
      StHigh: begin
        if (line_s) begin
          if (run_q == PulseLenRun) begin
            set_long = 1'b1;
            state_d  = StStuck;
          end else begin
            run_d = run_q + INT_RUN_W'(1);
          end
        end else begin
          if (run_q == PulseLenRun) begin
            evt = 1'b1;
          end else begin
            set_short = 1'b1;
          end
          run_d   = '0;
          state_d = StIdle;
        end
      end
      StStuck: begin
        // The low sample that leaves STUCK doubles as the inter-pulse separator.
        if (!line_s) begin
          run_d   = '0;
          state_d = StIdle;
        end
      end
      default: begin
        run_d   = '0;
        state_d = StIdle;
      end
    endcase
  end

  // Clear acts first so a same-cycle event or error still lands.
  always_comb begin
    out0_d      = evt;
    cnt_d       = clr ? '0 : cnt_q;
    err_short_d = (clr ? 1'b0 : err_short_q) | set_short;
    err_long_d  = (clr ? 1'b0 : err_long_q) | set_long;
    if (evt) begin
      cnt_d = cnt_d + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      run_q       <= '0;
      out0_q      <= 1'b0;
      err_short_q <= 1'b0;
      err_long_q  <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      run_q       <= run_d;
      out0_q      <= out0_d;
      err_short_q <= err_short_d;
      err_long_q  <= err_long_d;
      cnt_q       <= cnt_d;
    end
  end

  assign out0      = out0_q;
  assign err_short = err_short_q;
  assign err_long  = err_long_q;
  assign evt_count = cnt_q;

endmodule
